data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem_ext.sv | 21 ++
 rtl/data_mem.sv | 41 ++++
 tb/tb_data_mem.sv | 127 ++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared MIPS memory opcodes, data memory geometry and store decode helper
package data_mem_pkg;
  localparam int DM_DEPTH = 1024;
  localparam int DM_AW = 10;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SW || op == OP_SH || op == OP_SB;
  endfunction
endpackage

// File: rtl/data_mem_ext.sv
// dm_ext: combinational load extractor selecting and sign/zero-extending the addressed half or byte
module dm_ext
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [5:0]  op,
  output logic [31:0] dm
);
  logic [15:0] half;
  logic [7:0]  b;
  always_comb begin
    half = addr[1] ? word[31:16] : word[15:0];
    b = 8'(word >> {addr, 3'b000});
    dm = op == OP_LW  ? word :
         op == OP_LH  ? {{16{half[15]}}, half} :
         op == OP_LHU ? {16'h0, half} :
         op == OP_LB  ? {{24{b[7]}}, b} :
         op == OP_LBU ? {24'h0, b} : word;
  end
endmodule

// File: rtl/data_mem.sv
// data_mem: 1024x32 MEM-stage data memory with byte/half/word stores and read-old-data loads
module data_mem
  import data_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC4_M,
  input  logic [31:0] IR_M,
  input  logic [31:0] ALU_M,
  input  logic [31:0] WD_M,
  output logic [31:0] DM
);
  logic [31:0] mem_q [DM_DEPTH];
  logic [DM_AW-1:0] idx;
  logic [5:0] op;
  logic [4:0] sh;
  logic [31:0] old_w, mem_d;
  always_comb begin
    op = IR_M[31:26];
    idx = ALU_M[11:2];
    old_w = mem_q[idx];
    sh = {ALU_M[1:0], 3'b000};
    mem_d = op == OP_SW ? WD_M :
            op == OP_SH ? (ALU_M[1] ? {WD_M[15:0], old_w[15:0]} : {old_w[31:16], WD_M[15:0]}) :
            op == OP_SB ? ((old_w & ~(32'hFF << sh)) | ({24'h0, WD_M[7:0]} << sh)) : old_w;
  end
  dm_ext u_ext (.word(old_w), .addr(ALU_M[1:0]), .op(op), .dm(DM));
`ifndef SYNTHESIS
  initial for (int i = 0; i < DM_DEPTH; i++) mem_q[i] = '0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_DEPTH; i++) mem_q[i] <= '0;
    end else if (is_store(op)) begin
      mem_q[idx] <= mem_d;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, PC4_M - 32'd4, {ALU_M[31:2], 2'b00}, mem_d);
`endif
    end
  end
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed vector table plus randomized loads/stores against a byte-addressed model
module tb_data_mem;
  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, ADD = 6'b000000;

  logic clk = 0, reset = 0;
  logic [31:0] PC4_M = 0, IR_M = 0, ALU_M = 0, WD_M = 0, DM;
  int errors = 0, checks = 0;
  logic [7:0] mb [4096];

  data_mem dut (.clk(clk), .reset(reset), .PC4_M(PC4_M), .IR_M(IR_M), .ALU_M(ALU_M), .WD_M(WD_M), .DM(DM));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a);
    int w = int'(a[11:0]) & ~3;
    int h = int'(a[11:0]) & ~1;
    int y = int'(a[11:0]);
    logic [31:0] word = {mb[w + 3], mb[w + 2], mb[w + 1], mb[w]};
    logic [15:0] half = {mb[h + 1], mb[h]};
    logic [7:0] by = mb[y];
    case (op)
      LH: return {{16{half[15]}}, half};
      LHU: return {16'h0, half};
      LB: return {{24{by[7]}}, by};
      LBU: return {24'h0, by};
      default: return word;
    endcase
  endfunction

  task automatic model_edge(input logic r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    int w = int'(a[11:0]) & ~3;
    int h = int'(a[11:0]) & ~1;
    if (r) begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
    end else if (op == SW) begin
      for (int i = 0; i < 4; i++) mb[w + i] = wd[8*i +: 8];
    end else if (op == SH) begin
      mb[h] = wd[7:0];
      mb[h + 1] = wd[15:8];
    end else if (op == SB) begin
      mb[int'(a[11:0])] = wd[7:0];
    end
  endtask

  task automatic step(input logic r, input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic chk, input logic [31:0] exp, input string name);
    reset = r;
    IR_M = {op, 26'($urandom)};
    ALU_M = a;
    WD_M = wd;
    PC4_M = 32'h0040_0004 + (32'($urandom_range(0, 255)) << 2);
    #1;
    if (chk) begin
      checks++;
      if (DM !== exp) begin
        errors++;
        $display("FAIL %s: op=%b addr=%h DM=%h expected %h", name, op, a, DM, exp);
      end
    end
    @(posedge clk);
    model_edge(r, op, a, wd);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mb[i] = 8'h0;
    vq.push_back('{1'b1, LW,  32'h10,   32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, SW,  32'h10,   32'h12345678, 1'b1, 32'h0});
    vq.push_back('{1'b0, LW,  32'h10,   32'h0,        1'b1, 32'h12345678});
    vq.push_back('{1'b0, SB,  32'h11,   32'h000000AB, 1'b1, 32'h12345678});
    vq.push_back('{1'b0, LW,  32'h10,   32'h0,        1'b1, 32'h1234AB78});
    vq.push_back('{1'b0, LB,  32'h11,   32'h0,        1'b1, 32'hFFFFFFAB});
    vq.push_back('{1'b0, LBU, 32'h11,   32'h0,        1'b1, 32'h000000AB});
    vq.push_back('{1'b0, LHU, 32'h12,   32'h0,        1'b1, 32'h00001234});
    vq.push_back('{1'b0, SH,  32'h22,   32'h0000BEEF, 1'b1, 32'h0});
    vq.push_back('{1'b0, LW,  32'h20,   32'h0,        1'b1, 32'hBEEF0000});
    vq.push_back('{1'b0, LH,  32'h23,   32'h0,        1'b1, 32'hFFFFBEEF});
    vq.push_back('{1'b0, LHU, 32'h20,   32'h0,        1'b1, 32'h00000000});
    vq.push_back('{1'b0, LHU, 32'h22,   32'h0,        1'b1, 32'h0000BEEF});
    vq.push_back('{1'b0, SW,  32'h1004, 32'hCAFEF00D, 1'b1, 32'h0});
    vq.push_back('{1'b0, LW,  32'h0004, 32'h0,        1'b1, 32'hCAFEF00D});
    vq.push_back('{1'b0, SW,  32'h4,    32'h11111111, 1'b1, 32'hCAFEF00D});
    vq.push_back('{1'b0, LW,  32'hFFFF_F004, 32'h0,   1'b1, 32'h11111111});
    vq.push_back('{1'b1, SW,  32'h10,   32'hDEADBEEF, 1'b1, 32'h1234AB78});
    vq.push_back('{1'b0, LW,  32'h10,   32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, LB,  32'h7,    32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, ADD, 32'h10,   32'hFFFFFFFF, 1'b1, 32'h0});
    vq.push_back('{1'b0, LW,  32'h10,   32'h0,        1'b1, 32'h0});
    vq.push_back('{1'b0, SW,  32'h40,   32'hAAAAAAAA, 1'b1, 32'h0});
    vq.push_back('{1'b1, ADD, 32'h40,   32'h0,        1'b1, 32'hAAAAAAAA});
    vq.push_back('{1'b0, SB,  32'h40,   32'h00000055, 1'b1, 32'h0});
    vq.push_back('{1'b0, LW,  32'h40,   32'h0,        1'b1, 32'h00000055});
    vq.push_back('{1'b0, SH,  32'h41,   32'h00009234, 1'b1, 32'h00000055});
    vq.push_back('{1'b0, LH,  32'h40,   32'h0,        1'b1, 32'hFFFF9234});
    vq.push_back('{1'b0, SB,  32'h43,   32'h000000C3, 1'b1, 32'h00009234});
    vq.push_back('{1'b0, LB,  32'h43,   32'h0,        1'b1, 32'hFFFFFFC3});
    vq.push_back('{1'b0, ADD, 32'h42,   32'h0,        1'b1, 32'hC3009234});
    foreach (vq[i]) step(vq[i].rst, vq[i].op, vq[i].a, vq[i].wd, vq[i].chk, vq[i].exp, $sformatf("vec%0d", i));

    for (int n = 0; n < 400; n++) begin
      logic [5:0] ops [9];
      logic [5:0] op;
      logic [31:0] a;
      logic r;
      ops = '{SW, SH, SB, LW, LH, LHU, LB, LBU, ADD};
      op = ops[$urandom_range(0, 8)];
      if (op == ADD) op = 6'($urandom);
      a = {20'($urandom), 6'($urandom_range(0, 15)), 4'($urandom), 2'($urandom)};
      r = ($urandom_range(0, 60) == 0);
      step(r, op, a, $urandom, 1'b1, model_load(op, a), $sformatf("rand%0d", n));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
